// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_pkg;

    localparam int LINE_W      = 128;
    localparam int HW_PER_LINE = 8;

    typedef enum logic [1:0] {
        S_REQUEST = 2'd0,
        S_FILL    = 2'd1,
        S_INSTALL = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    // Select halfword idx (0..7) out of a 128-bit line.
    function automatic logic [15:0] hw_sel(input logic [LINE_W-1:0] line, input logic [2:0] idx);
        return line[{idx, 4'd0} +: 16];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
interface icache_if;
    logic         proc_read;
    logic [31:0]  proc_addr;
    logic         flush;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    // Environment side: core fetch stage plus instruction memory.
    modport master (
        output proc_read, proc_addr, flush, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_addr
    );

    // Cache side.
    modport slave (
        input  proc_read, proc_addr, flush, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/data for SETS entries, two lookup ports, one write port.
module icache_way
    import icache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 28 - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [TAG_W-1:0]  a_tag,
    output logic              a_hit,
    output logic [LINE_W-1:0] a_data,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [TAG_W-1:0]  b_tag,
    output logic              b_hit,
    output logic [LINE_W-1:0] b_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);
    logic [SETS-1:0]   valid_r;
    logic [TAG_W-1:0]  tag_r  [SETS];
    logic [LINE_W-1:0] data_r [SETS];

    // Valid bits: cleared by reset or the flush sweep, set on install.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (clr_en) begin
            valid_r[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload written on install; no reset needed behind valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign a_hit    = valid_r[a_idx] && (tag_r[a_idx] == a_tag);
    assign a_data   = data_r[a_idx];
    assign b_hit    = valid_r[b_idx] && (tag_r[b_idx] == b_tag);
    assign b_data   = data_r[b_idx];
    assign wr_valid = valid_r[wr_idx];

endmodule

// File: rtl/icache_sa.sv
// Set-associative RV32IC instruction cache with LRU, line-crossing fetch and flush sweep.
module icache_sa
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 28 - IDX_W
) (
    input logic     clk,
    input logic     proc_reset_n,
    icache_if.slave bus
);
    state_t            state_r;
    logic              flush_pending_r;
    logic [27:0]       fill_line_r;
    logic [LINE_W-1:0] line_buf_r;
    logic [IDX_W-1:0]  set_cnt_r;
    logic [SETS-1:0]   lru_r;       // per set: index of the least recently used way

    logic [27:0]       line_a_s, line_b_s, fill_line_s;
    logic [IDX_W-1:0]  idx_a_s, idx_b_s, fill_idx_s;
    logic [2:0]        off_s;
    logic [WAYS-1:0]   a_hit_w, b_hit_w, fill_valid_w, wr_en_w;
    logic [LINE_W-1:0] a_data_w [WAYS];
    logic [LINE_W-1:0] b_data_w [WAYS];
    logic [LINE_W-1:0] a_line_s, b_line_s;
    logic              a_hit_s, b_hit_s, a_way_s, b_way_s, victim_s;
    logic              cross_s, hit_s, flush_req_s, serve_s, miss_req_s;
    logic [15:0]       h_s;
    logic [31:0]       rdata_s;

    assign line_a_s   = bus.proc_addr[31:4];
    assign line_b_s   = line_a_s + 28'd1;          // wraps modulo 2^28
    assign off_s      = bus.proc_addr[3:1];
    assign idx_a_s    = line_a_s[IDX_W-1:0];
    assign idx_b_s    = line_b_s[IDX_W-1:0];
    assign fill_idx_s = fill_line_r[IDX_W-1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
            .clk      (clk),
            .rst_n    (proc_reset_n),
            .a_idx    (idx_a_s),
            .a_tag    (line_a_s[27:IDX_W]),
            .a_hit    (a_hit_w[w]),
            .a_data   (a_data_w[w]),
            .b_idx    (idx_b_s),
            .b_tag    (line_b_s[27:IDX_W]),
            .b_hit    (b_hit_w[w]),
            .b_data   (b_data_w[w]),
            .wr_en    (wr_en_w[w]),
            .wr_idx   (fill_idx_s),
            .wr_tag   (fill_line_r[27:IDX_W]),
            .wr_data  (line_buf_r),
            .wr_valid (fill_valid_w[w]),
            .clr_en   (state_r == S_FLUSH),
            .clr_idx  (set_cnt_r)
        );
        assign wr_en_w[w] = proc_reset_n && (state_r == S_INSTALL) && (victim_s == 1'(w));
    end

    // Merge per-way lookup results; at most one way hits per line.
    always_comb begin
        a_line_s = '0;
        b_line_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            a_line_s = a_line_s | ({LINE_W{a_hit_w[w]}} & a_data_w[w]);
            b_line_s = b_line_s | ({LINE_W{b_hit_w[w]}} & b_data_w[w]);
        end
    end

    assign a_hit_s = |a_hit_w;
    assign b_hit_s = |b_hit_w;
    assign a_way_s = (WAYS == 2) ? a_hit_w[WAYS-1] : 1'b0;
    assign b_way_s = (WAYS == 2) ? b_hit_w[WAYS-1] : 1'b0;

    // A 32-bit instruction in the last halfword needs line B as well.
    assign h_s         = hw_sel(a_line_s, off_s);
    assign cross_s     = a_hit_s && (off_s == 3'd7) && (h_s[1:0] == 2'b11);
    assign hit_s       = a_hit_s && (!cross_s || b_hit_s);
    assign flush_req_s = bus.flush || flush_pending_r;
    assign serve_s     = proc_reset_n && (state_r == S_REQUEST) && bus.proc_read && !flush_req_s && hit_s;
    assign miss_req_s  = proc_reset_n && (state_r == S_REQUEST) && bus.proc_read && !flush_req_s && !hit_s;
    assign fill_line_s = a_hit_s ? line_b_s : line_a_s;

    // Assemble the instruction word from one or two lines.
    always_comb begin
        if (off_s != 3'd7) begin
            rdata_s = {hw_sel(a_line_s, off_s + 3'd1), h_s};
        end else if (cross_s) begin
            rdata_s = {hw_sel(b_line_s, 3'd0), h_s};
        end else begin
            rdata_s = {16'd0, h_s};
        end
    end

    // Victim: lowest invalid way, otherwise the LRU way of the fill set.
    always_comb begin
        victim_s = 1'b0;
        if (WAYS == 2) begin
            if (!fill_valid_w[0]) begin
                victim_s = 1'b0;
            end else if (!fill_valid_w[WAYS-1]) begin
                victim_s = 1'b1;
            end else begin
                victim_s = lru_r[fill_idx_s];
            end
        end else begin
            victim_s = 1'b0;
        end
    end

    // Line address to memory: live on the miss cycle, held from the register in FILL.
    always_comb begin
        bus.mem_addr = 28'd0;
        if (proc_reset_n && (state_r == S_FILL)) begin
            bus.mem_addr = fill_line_r;
        end else if (miss_req_s) begin
            bus.mem_addr = fill_line_s;
        end else begin
            bus.mem_addr = 28'd0;
        end
    end

    assign bus.proc_stall = proc_reset_n && ((state_r != S_REQUEST) || (bus.proc_read && !serve_s));
    assign bus.proc_rdata = serve_s ? rdata_s : 32'd0;
    assign bus.mem_read   = proc_reset_n && ((state_r == S_FILL) || miss_req_s);

    // Control FSM: miss capture, fill wait, install, and the flush sweep.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_r         <= S_REQUEST;
            flush_pending_r <= 1'b0;
            fill_line_r     <= 28'd0;
            line_buf_r      <= '0;
            set_cnt_r       <= '0;
        end else begin
            case (state_r)
                S_REQUEST: begin
                    if (flush_req_s) begin
                        state_r         <= S_FLUSH;
                        flush_pending_r <= 1'b0;
                        set_cnt_r       <= '0;
                    end else if (miss_req_s) begin
                        fill_line_r <= fill_line_s;
                        state_r     <= S_FILL;
                    end else begin
                        state_r <= S_REQUEST;
                    end
                end
                S_FILL: begin
                    if (bus.flush) begin
                        flush_pending_r <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        line_buf_r <= bus.mem_rdata;
                        state_r    <= S_INSTALL;
                    end
                end
                S_INSTALL: begin
                    if (bus.flush) begin
                        flush_pending_r <= 1'b1;
                    end
                    state_r <= S_REQUEST;
                end
                S_FLUSH: begin
                    set_cnt_r <= set_cnt_r + IDX_W'(1);
                    if (set_cnt_r == IDX_W'(SETS - 1)) begin
                        state_r <= S_REQUEST;
                    end
                end
                default: begin
                    state_r <= S_REQUEST;
                end
            endcase
        end
    end

    // LRU bits: cleared by reset/flush, updated on install and on every served hit.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            lru_r <= '0;
        end else if (state_r == S_FLUSH) begin
            lru_r[set_cnt_r] <= 1'b0;
        end else if (state_r == S_INSTALL) begin
            lru_r[fill_idx_s] <= ~victim_s;
        end else if (serve_s) begin
            lru_r[idx_a_s] <= ~a_way_s;
            if (cross_s) begin
                lru_r[idx_b_s] <= ~b_way_s;
            end
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed self-checking bench for icache_sa (WAYS=2, SETS=8).
module tb_icache_sa;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    icache_if bus ();

    icache_sa #(.WAYS(2), .SETS(8)) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [127:0] L_COLD = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] L_C    = 128'h0001_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] L_10   = 128'h0513_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1234;
    localparam logic [127:0] L_11   = 128'h5555_4444_3333_2222_1111_0000_ABCD_9876;
    localparam logic [127:0] L_W    = 128'h0003_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [127:0] L_0    = 128'h0000_0000_0000_0000_0000_0000_0000_BEEF;
    localparam logic [127:0] L_A    = 128'h0000_0000_0000_0000_0000_0000_A1A1_A0A0;
    localparam logic [127:0] L_B    = 128'h0000_0000_0000_0000_0000_0000_B1B1_B0B0;
    localparam logic [127:0] L_CC   = 128'h0000_0000_0000_0000_0000_0000_C1C1_C0C0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.proc_read = 1'b0;
        bus.proc_addr = 32'd0;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 128'd0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Miss on addr, memory answers in the first FILL cycle; returns in the REQUEST cycle after INSTALL.
    task automatic fill_line(input logic [31:0] addr, input logic [127:0] data);
        bus.proc_read = 1'b1;
        bus.proc_addr = addr;
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = data;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.proc_read = 1'b0;
        bus.proc_addr = 32'h0000_0100;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 128'd0;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL rst_in_stall: got %b want 0", bus.proc_stall); end
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL rst_in_mem_read: got %b want 0", bus.mem_read); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL rst_out_stall: got %b want 0", bus.proc_stall); end
        vectors++; if (bus.proc_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_out_rdata: got %h want 0", bus.proc_rdata); end
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL rst_out_mem_read: got %b want 0", bus.mem_read); end
        vectors++; if (bus.mem_addr !== 28'd0) begin miscompares++; $display("FAIL rst_out_mem_addr: got %h want 0", bus.mem_addr); end
    endtask

    task automatic test_cold_miss();
        do_reset();
        bus.proc_read = 1'b1;
        bus.proc_addr = 32'h0000_0100;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL cold_stall: got %b want 1", bus.proc_stall); end
        vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("FAIL cold_mem_read: got %b want 1", bus.mem_read); end
        vectors++; if (bus.mem_addr !== 28'h000_0010) begin miscompares++; $display("FAIL cold_mem_addr: got %h want 0000010", bus.mem_addr); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 28'h000_0010) begin miscompares++; $display("FAIL cold_fill_addr_held: got %h want 0000010", bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_COLD;
        next_cycle();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL cold_install_stall: got %b want 1", bus.proc_stall); end
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL cold_install_mem_read: got %b want 0", bus.mem_read); end
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL cold_served_stall: got %b want 0", bus.proc_stall); end
        vectors++; if (bus.proc_rdata !== 32'h0302_0100) begin miscompares++; $display("FAIL cold_served_rdata: got %h want 03020100", bus.proc_rdata); end
    endtask

    task automatic test_compressed_hit();
        do_reset();
        fill_line(32'h0000_0100, L_C);
        bus.proc_addr = 32'h0000_010E;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL cmp_stall: got %b want 0", bus.proc_stall); end
        vectors++; if (bus.proc_rdata !== 32'h0000_0001) begin miscompares++; $display("FAIL cmp_rdata: got %h want 00000001", bus.proc_rdata); end
        vectors++; if (bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL cmp_mem_read: got %b want 0", bus.mem_read); end
        next_cycle();
        bus.proc_addr = 32'h0000_0104;
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'h4444_5555) begin miscompares++; $display("FAIL mid_rdata: got %h want 44445555", bus.proc_rdata); end
        next_cycle();
        bus.proc_addr = 32'h0000_010C;
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'h0001_1111) begin miscompares++; $display("FAIL off6_rdata: got %h want 00011111", bus.proc_rdata); end
        next_cycle();
        bus.proc_read = 1'b0;
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'd0) begin miscompares++; $display("FAIL idle_rdata: got %h want 0", bus.proc_rdata); end
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL idle_stall: got %b want 0", bus.proc_stall); end
    endtask

    task automatic test_cross_line();
        do_reset();
        fill_line(32'h0000_0100, L_10);
        bus.proc_addr = 32'h0000_010E;
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 28'h000_0011) begin miscompares++; $display("FAIL cross_b_addr: got %h want 0000011", bus.mem_addr); end
        vectors++; if (bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL cross_b_stall: got %b want 1", bus.proc_stall); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_11;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'h9876_0513) begin miscompares++; $display("FAIL cross_rdata: got %h want 98760513", bus.proc_rdata); end
        // Double miss: line A then line B.
        do_reset();
        bus.proc_read = 1'b1;
        bus.proc_addr = 32'h0000_010E;
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 28'h000_0010) begin miscompares++; $display("FAIL dbl_first_addr: got %h want 0000010", bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_10;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 28'h000_0011) begin miscompares++; $display("FAIL dbl_second_addr: got %h want 0000011", bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_11;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'h9876_0513) begin miscompares++; $display("FAIL dbl_rdata: got %h want 98760513", bus.proc_rdata); end
        // Line B of the top line wraps to line 0.
        do_reset();
        fill_line(32'hFFFF_FFF0, L_W);
        bus.proc_addr = 32'hFFFF_FFFE;
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h000_0000) begin miscompares++; $display("FAIL wrap_addr: got rd=%b addr=%h want rd=1 addr=0000000", bus.mem_read, bus.mem_addr); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_0;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'hBEEF_0003) begin miscompares++; $display("FAIL wrap_rdata: got %h want beef0003", bus.proc_rdata); end
    endtask

    task automatic test_lru();
        do_reset();
        fill_line(32'h0000_0000, L_A);
        fill_line(32'h0000_0080, L_B);
        bus.proc_addr = 32'h0000_0000;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'hA1A1_A0A0) begin miscompares++; $display("FAIL lru_touch: got stall=%b rdata=%h want 0 a1a1a0a0", bus.proc_stall, bus.proc_rdata); end
        next_cycle();
        fill_line(32'h0000_0100, L_CC);
        @(negedge clk);
        vectors++; if (bus.proc_rdata !== 32'hC1C1_C0C0) begin miscompares++; $display("FAIL lru_new_rdata: got %h want c1c1c0c0", bus.proc_rdata); end
        next_cycle();
        bus.proc_addr = 32'h0000_0000;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0 || bus.proc_rdata !== 32'hA1A1_A0A0) begin miscompares++; $display("FAIL lru_keep_mru: got stall=%b rdata=%h want 0 a1a1a0a0", bus.proc_stall, bus.proc_rdata); end
        next_cycle();
        bus.proc_addr = 32'h0000_0080;
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h000_0008) begin miscompares++; $display("FAIL lru_evicted: got rd=%b addr=%h want rd=1 addr=0000008", bus.mem_read, bus.mem_addr); end
    endtask

    task automatic test_flush_in_fill();
        do_reset();
        fill_line(32'h0000_0100, L_COLD);
        bus.proc_addr = 32'h0000_0200;
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 28'h000_0020) begin miscompares++; $display("FAIL fl_miss_addr: got %h want 0000020", bus.mem_addr); end
        next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_C;
        next_cycle();
        bus.mem_ready = 1'b0;
        bus.proc_read = 1'b0;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL fl_install_stall: got %b want 1", bus.proc_stall); end
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL fl_pending_stall: got %b want 0", bus.proc_stall); end
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk);
            vectors++; if (bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL fl_sweep_stall[%0d]: got %b want 1", i, bus.proc_stall); end
        end
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL fl_done_stall: got %b want 0", bus.proc_stall); end
        next_cycle();
        bus.proc_read = 1'b1;
        bus.proc_addr = 32'h0000_0100;
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h000_0010) begin miscompares++; $display("FAIL fl_rehit_misses: got rd=%b addr=%h want rd=1 addr=0000010", bus.mem_read, bus.mem_addr); end
    endtask

    task automatic test_flush_priority();
        do_reset();
        fill_line(32'h0000_0100, L_COLD);
        bus.flush = 1'b1;
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL fp_stall: got stall=%b rd=%b want 1 0", bus.proc_stall, bus.mem_read); end
        next_cycle();
        bus.flush = 1'b0;
        for (int i = 1; i < 8; i++) begin
            next_cycle();
        end
        @(negedge clk);
        vectors++; if (bus.proc_stall !== 1'b1 || bus.mem_read !== 1'b0) begin miscompares++; $display("FAIL fp_last_sweep: got stall=%b rd=%b want 1 0", bus.proc_stall, bus.mem_read); end
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h000_0010) begin miscompares++; $display("FAIL fp_after_sweep: got rd=%b addr=%h want rd=1 addr=0000010", bus.mem_read, bus.mem_addr); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus.proc_read = 1'b1;
        bus.proc_addr = 32'h0000_0100;
        next_cycle();
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1) begin miscompares++; $display("FAIL rmf_in_fill: got %b want 1", bus.mem_read); end
        rst_n = 1'b0;
        bus.proc_read = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b0 || bus.proc_stall !== 1'b0) begin miscompares++; $display("FAIL rmf_aborted: got rd=%b stall=%b want 0 0", bus.mem_read, bus.proc_stall); end
        next_cycle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = L_COLD;
        next_cycle();
        bus.mem_ready = 1'b0;
        next_cycle();
        bus.proc_read = 1'b1;
        @(negedge clk);
        vectors++; if (bus.mem_read !== 1'b1 || bus.proc_stall !== 1'b1) begin miscompares++; $display("FAIL rmf_reread_misses: got rd=%b stall=%b want 1 1", bus.mem_read, bus.proc_stall); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_cold_miss();
        test_compressed_hit();
        test_cross_line();
        test_lru();
        test_flush_in_fill();
        test_flush_priority();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache for the RV32IC core, between the IF stage and the 128-bit instruction memory.
- Adds configurable sets and ways, LRU replacement, and a flush sweep for fence.i.
- Self-decodes compressed instructions at halfword granularity. A 32-bit instruction straddling two lines is assembled from two properly tagged lines.

Parameters:
- WAYS, 2, associativity; legal values are 1 and 2.
- SETS, 8, number of sets; power of two, 2..64.
- IDX_W, $clog2(SETS), index width (derived).
- TAG_W, 28-IDX_W, tag width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- proc_reset_n  in  1  reset, synchronous, active-low.
- proc_read  in  1  fetch request.
- proc_addr  in  32  fetch PC; bit0 ignored.
- flush  in  1  one-cycle pulse: invalidate all lines.
- proc_stall  out  1  fetch not served this cycle.
- proc_rdata  out  32  instruction bits starting at proc_addr; upper 16 bits are don't-care for compressed instructions.
- mem_read  out  1  line read request.
- mem_addr  out  28  line address, PC[31:4].
- mem_rdata  in  128  returned line.
- mem_ready  in  1  mem_rdata valid this cycle.

Behaviour:
- Address fields: offset=addr[3:1], index=addr[4+IDX_W-1:4], tag=addr[31:4+IDX_W].
- Line A is PC[31:4]; line B is PC[31:4]+1, wrapping modulo 2^28.
- Reset (proc_reset_n=0 at an edge): all valid and LRU bits cleared, state=REQUEST, flush_pending=0.
- During and after reset, proc_stall=0, proc_rdata=0, mem_read=0, mem_addr=0 until a request arrives.
- Reset during FILL aborts the fill; mem_read is 0 from the next cycle and a late mem_ready is ignored.
- Halfword h = line A halfword[offset].
- cross = (offset==7) && (h[1:0]==2'b11). cross is only evaluated when line A hits.
- If offset==7 and not cross: proc_rdata = {16'd0, h}.
- If cross: proc_rdata = {line B halfword0, h}.
- Otherwise: proc_rdata = the 32 bits at halfwords offset and offset+1 of line A.
- Hit: line A hits and, if cross, line B also hits.
- On a hit, in REQUEST, stall=0 and rdata is valid combinationally (0-cycle latency). The LRU of each accessed set marks the hit way as MRU at the edge.
- proc_read=0: no stall, no fill, LRU unchanged, rdata=0.
- FSM states: REQUEST, FILL, INSTALL, FLUSH.
  - REQUEST, proc_read and miss: stall=1. Capture fill line = A if A misses, else B. Assert mem_read with mem_addr in the same cycle; go to FILL.
  - FILL: mem_read=1 and mem_addr held constant; stall=1. On mem_ready, latch mem_rdata and go to INSTALL.
  - INSTALL: stall=1. Write tag, data, and valid into the victim way and mark it MRU; go to REQUEST, where the access is re-evaluated. A cross-line double miss therefore performs two fill sequences.
  - Victim selection: lowest invalid way, else the LRU way; with WAYS=1, way 0.
  - Miss latency: the instruction is served in the REQUEST cycle after INSTALL, i.e. 2 cycles after mem_ready.
  - flush in REQUEST: go to FLUSH and clear valid[set] for all ways, one set per cycle, over SETS cycles using a set counter.
  - FLUSH: stall=1; the LRU is also cleared. Return to REQUEST after the last set.
  - flush arriving in FILL or INSTALL sets flush_pending. The fill completes and installs, then FLUSH is entered from REQUEST before any hit is served.
  - flush together with proc_read in REQUEST: flush has priority; stall=1.
- mem_ready outside FILL is ignored.
- mem_write does not exist; the cache is read-only.

Decomposition:
- Package icache_pkg: state encoding, LINE_W=128, HW_PER_LINE=8, and a function hw_sel(line, idx) returning a 16-bit halfword.
- Sub-module icache_way: one way's tag/valid/data storage for SETS entries. It has two combinational read ports (lines A and B), one synchronous write port, and a synchronous valid clear by index. The top instantiates WAYS copies plus the LRU bits, FSM, and output muxes.

Test Plan:
- Cold miss: reset, read 0x0000_0100 (all ways invalid) -> stall=1, mem_read=1, mem_addr=0x000_0010. Memory returns line L after 3 cycles -> installed in way 0. The next REQUEST cycle gives stall=0, rdata = L[31:0].
- Compressed hit: line holds 0x0001 at halfword 7, read 0x0000_010E -> stall=0 immediately, rdata[15:0]=0x0001, no mem_read.
- Cross line: halfword 7 of line 0x10 = 0x0513, line 0x11 uncached, read 0x0000_010E -> one fill for 0x011, then rdata = {L11[15:0], 16'h0513}. The double-miss case shows two fills: 0x010, then 0x011.
- LRU (WAYS=2, SETS=8): fill addresses 0x000, 0x080, touch 0x000, then read 0x100 -> victim is the way holding 0x080. A re-read of 0x000 hits; a re-read of 0x080 misses.
- Flush: pulse flush while in FILL -> the fill completes, then stall stays 1 for exactly 8 FLUSH cycles. A previously hit address then misses.
- Reset mid-fill: deassert proc_reset_n in FILL -> next cycle mem_read=0, stall=0, state REQUEST. A later mem_ready causes no install, and a re-read misses.
